// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: host FSM states, grant
// encoding and the width of the optional stall counter.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_RESP = 2'd2
  } host_state_e;

  typedef logic [1:0] grant_t;

  localparam grant_t GNT_DISP  = 2'd0;
  localparam grant_t GNT_DRAIN = 2'd1;
  localparam grant_t GNT_HREAD = 2'd2;
  localparam grant_t GNT_NONE  = 2'd3;

  localparam int STATS_WIDTH = 16;

endpackage

// File: rtl/vram_wr_fifo.sv
// Posted-write FIFO holding {addr,data} pairs; supports push and pop in the
// same cycle, including when full. Head entry is presented combinationally.
module vram_wr_fifo #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]                 wr_ptr;
  logic [PTR_W-1:0]                 rd_ptr;
  logic [CNT_W-1:0]                 count;
  logic                             do_push;
  logic                             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);

  assign {head_addr, head_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_addr, push_data};
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between the display fetcher and a
// host port. Optional stall counter enabled by defining VRAM_ARB_STATS_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_disp_req,
  input  logic [ADDR_WIDTH-1:0] i_disp_addr,
  output logic                  o_disp_valid,
  output logic [DATA_WIDTH-1:0] o_disp_data,
  input  logic                  i_host_valid,
  input  logic                  i_host_we,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_data,
  output logic                  o_host_ready,
  output logic                  o_host_rvalid,
  output logic [DATA_WIDTH-1:0] o_host_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic [1:0]            dbg_host_state
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] o_host_stall_cycles
`endif
);

  host_state_e           state;
  host_state_e           state_next;
  grant_t                grant;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ADDR_WIDTH-1:0] fifo_addr;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  disp_valid_q;
  logic                  accept;
  logic                  accept_rd;

  // Host handshake: a command transfers in any cycle where i_host_valid and
  // o_host_ready are both high; the host holds its command until then.
  assign o_host_ready = (state == H_IDLE) && !fifo_full && !i_reset;
  assign accept       = i_host_valid && o_host_ready;
  assign fifo_push    = accept && i_host_we;
  assign accept_rd    = accept && !i_host_we;
  assign fifo_pop     = (grant == GNT_DRAIN) && !i_reset;

  vram_wr_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (fifo_push),
    .push_addr (i_host_addr),
    .push_data (i_host_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (fifo_addr),
    .head_data (fifo_data)
  );

  // Host reads wait for an empty FIFO so they observe every earlier write.
  always_comb begin
    grant = GNT_NONE;
    if (i_disp_req)           grant = GNT_DISP;
    else if (!fifo_empty)     grant = GNT_DRAIN;
    else if (state == H_WAIT) grant = GNT_HREAD;
  end

  always_comb begin
    o_ram_addr = last_addr;
    o_ram_we   = 1'b0;
    case (grant)
      GNT_DISP:  o_ram_addr = i_disp_addr;
      GNT_DRAIN: begin
        o_ram_addr = fifo_addr;
        o_ram_we   = !i_reset;
      end
      GNT_HREAD: o_ram_addr = host_addr;
      default:   o_ram_addr = last_addr;
    endcase
  end

  assign o_ram_data = fifo_data;

  always_comb begin
    state_next = state;
    case (state)
      H_IDLE:  if (accept_rd) state_next = H_WAIT;
      H_WAIT:  if (grant == GNT_HREAD) state_next = H_RESP;
      H_RESP:  state_next = H_IDLE;
      default: state_next = H_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= H_IDLE;
      host_addr    <= '0;
      last_addr    <= '0;
      rdata_q      <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state        <= state_next;
      last_addr    <= o_ram_addr;
      disp_valid_q <= i_disp_req;
      if (accept_rd)        host_addr <= i_host_addr;
      if (state == H_RESP)  rdata_q   <= i_ram_data;
    end
  end

  // RAM data is registered, so both read paths see it one cycle after issue.
  assign o_disp_valid   = disp_valid_q;
  assign o_disp_data    = i_ram_data;
  assign o_host_rvalid  = (state == H_RESP) && !i_reset;
  assign o_host_rdata   = (state == H_RESP) ? i_ram_data : rdata_q;
  assign dbg_host_state = state;

`ifdef VRAM_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] stall_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_q <= '0;
    end else if (((i_host_valid && !o_host_ready) || state == H_WAIT) && (stall_q != '1)) begin
      stall_q <= stall_q + STATS_WIDTH'(1);
    end
  end

  assign o_host_stall_cycles = stall_q;
`else
  // Stall counter is not built in this configuration.
`endif

endmodule
